game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_counter.sv | 28 ++
 rtl/game_state_ctrl.sv | 133 +++++++++++++
 tb/tb_game_state_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the game controller: FSM state codes and RGB mux selects.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam logic [1:0] RGB_BG   = 2'd0;
    localparam logic [1:0] RGB_OBJ  = 2'd1;
    localparam logic [1:0] RGB_OVER = 2'd2;

    localparam int CNT_W = 8;

    function automatic logic in_game(input game_state_t s);
        return (s == ST_PLAY) || (s == ST_HIT);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// 8-bit frame_tick counter with synchronous clear, saturating at TC.
// done is high once TC is reached, including the cycle of the tick that reaches it.
module frame_counter
    import game_pkg::*;
#(
    parameter int unsigned TC = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != CNT_W'(TC))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(TC)) || (tick && (count == CNT_W'(TC - 1)));

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE -> PLAY -> HIT (grace) / OVER (hold), lives and display selects.
// Optional score counter enabled by defining GAME_CTRL_SCORE_EN.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT       = 3,
    parameter int unsigned HIT_GRACE_FRAMES = 60,
    parameter int unsigned OVER_HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        key_start,
    input  logic        collision,
    output logic [1:0]  game_state,
    output logic        game_en,
    output logic        game_over_object,
    output logic        object_reset,
    output logic        obj_visible,
    output logic [1:0]  lives,
    output logic [1:0]  rgb_sel
`ifdef GAME_CTRL_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    game_state_t      state, state_next;
    logic             key_prev, start_evt;
    logic             hit_evt, start_ok;
    logic [CNT_W-1:0] grace_count;
    logic [CNT_W-1:0] over_count_unused;
    logic             grace_done, over_done;

    // History resets to 1 so a key already held at reset release is not a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev  <= 1'b1;
            start_evt <= 1'b0;
        end else begin
            key_prev  <= key_start;
            start_evt <= key_start & ~key_prev;
        end
    end

    assign hit_evt  = (state == ST_PLAY) && collision;
    assign start_ok = start_evt && ((state == ST_IDLE) || ((state == ST_OVER) && over_done));

    frame_counter #(.TC(HIT_GRACE_FRAMES)) u_grace (
        .clk   (clk),
        .reset (reset),
        .clear (hit_evt),
        .tick  ((state == ST_HIT) && frame_tick),
        .count (grace_count),
        .done  (grace_done)
    );

    frame_counter #(.TC(OVER_HOLD_FRAMES)) u_over (
        .clk   (clk),
        .reset (reset),
        .clear (hit_evt),
        .tick  ((state == ST_OVER) && frame_tick),
        .count (over_count_unused),
        .done  (over_done)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_ok) state_next = ST_PLAY;
            ST_PLAY: if (collision) state_next = (lives > 2'd1) ? ST_HIT : ST_OVER;
            ST_HIT:  if (frame_tick && grace_done) state_next = ST_PLAY;
            ST_OVER: if (start_ok) state_next = ST_PLAY;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lives        <= 2'd0;
            object_reset <= 1'b0;
        end else begin
            state        <= state_next;
            object_reset <= start_ok;
            if (start_ok) begin
                lives <= 2'(LIVES_INIT);
            end else if (hit_evt) begin
                lives <= (lives > 2'd1) ? lives - 2'd1 : 2'd0;
            end
        end
    end

    always_comb begin
        game_en          = 1'b0;
        game_over_object = 1'b0;
        obj_visible      = 1'b0;
        rgb_sel          = RGB_BG;
        unique case (state)
            ST_PLAY: begin
                game_en     = 1'b1;
                obj_visible = 1'b1;
                rgb_sel     = RGB_OBJ;
            end
            ST_HIT: begin
                game_en     = 1'b1;
                obj_visible = grace_count[3];  // blinks with an 8-frame half period
                rgb_sel     = RGB_OBJ;
            end
            ST_OVER: begin
                game_over_object = 1'b1;
                obj_visible      = 1'b1;
                rgb_sel          = RGB_OVER;
            end
            default: ;
        endcase
    end

    assign game_state = state;

`ifdef GAME_CTRL_SCORE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= 16'd0;
        end else if (start_ok) begin
            score <= 16'd0;
        end else if (frame_tick && in_game(state) && (score != 16'hFFFF)) begin
            score <= score + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus randomized stimulus
// against a frame/tick-level behavioural model.
module tb_game_state_ctrl;

    localparam int LIVES = 3;
    localparam int GRACE = 60;
    localparam int HOLD  = 120;
    localparam int EW    = 26;

    logic        clk, reset, frame_tick, key_start, collision;
    logic [1:0]  game_state, lives, rgb_sel;
    logic        game_en, game_over_object, object_reset, obj_visible;
`ifdef GAME_CTRL_SCORE_EN
    logic [15:0] score;
`endif

    game_state_ctrl #(
        .LIVES_INIT       (LIVES),
        .HIT_GRACE_FRAMES (GRACE),
        .OVER_HOLD_FRAMES (HOLD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .key_start        (key_start),
        .collision        (collision),
        .game_state       (game_state),
        .game_en          (game_en),
        .game_over_object (game_over_object),
        .object_reset     (object_reset),
        .obj_visible      (obj_visible),
        .lives            (lives),
        .rgb_sel          (rgb_sel)
`ifdef GAME_CTRL_SCORE_EN
        ,
        .score            (score)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0=idle 1=play 2=hit 3=over, ticks counted as plain integers.
    int m_state, m_lives, m_grace, m_over, m_score;
    bit m_prev, m_start, m_objrst;

    function automatic void model_reset();
        m_state = 0; m_lives = 0; m_grace = 0; m_over = 0; m_score = 0;
        m_prev = 1'b1; m_start = 1'b0; m_objrst = 1'b0;
    endfunction

    function automatic void new_game();
        m_state = 1; m_lives = LIVES; m_objrst = 1'b1; m_score = 0;
    endfunction

    function automatic void model_step(input bit ks, input bit col, input bit ft);
        bit start_now;
        start_now = m_start;
        m_start   = ks && !m_prev;
        m_prev    = ks;
        m_objrst  = 1'b0;
        if (ft && (m_state == 1 || m_state == 2) && m_score < 65535) m_score++;
        case (m_state)
            0: if (start_now) new_game();
            1: if (col) begin
                if (m_lives > 1) begin
                    m_lives--; m_state = 2; m_grace = 0;
                end else begin
                    m_lives = 0; m_state = 3; m_over = 0;
                end
            end
            2: if (ft) begin
                m_grace++;
                if (m_grace == GRACE) m_state = 1;
            end
            3: begin
                if (ft && m_over < HOLD) m_over++;
                if (start_now && m_over == HOLD) new_game();
            end
            default: ;
        endcase
    endfunction

    function automatic logic [EW-1:0] model_out();
        logic [1:0] rgb;
        bit vis;
        rgb = (m_state == 0) ? 2'd0 : (m_state == 3) ? 2'd2 : 2'd1;
        vis = (m_state == 0) ? 1'b0 : (m_state == 2) ? bit'((m_grace / 8) % 2) : 1'b1;
        return {16'(m_score), 2'(m_state), bit'(m_state == 1 || m_state == 2),
                bit'(m_state == 3), vis, m_objrst, 2'(m_lives), rgb};
    endfunction

    // scoreboard
    task automatic check_outputs();
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("game_state", game_state, e[9:8]);
        chk("game_en", game_en, e[7]);
        chk("game_over_object", game_over_object, e[6]);
        chk("obj_visible", obj_visible, e[5]);
        chk("object_reset", object_reset, e[4]);
        chk("lives", lives, e[3:2]);
        chk("rgb_sel", rgb_sel, e[1:0]);
`ifdef GAME_CTRL_SCORE_EN
        chk("score", score, e[25:10]);
`endif
    endtask

    // driver tasks (entered and left at a negedge)
    task automatic cycle(input bit ks, input bit col, input bit ft);
        key_start = ks; collision = col; frame_tick = ft;
        @(posedge clk);
        model_step(ks, col, ft);
        exp_q.push_back(model_out());
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n, input bit col);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, col, 1'b1);
            for (int j = 0; j < 3; j++) cycle(1'b0, col, 1'b0);
        end
    endtask

    task automatic press();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input bit ks);
        key_start = ks; collision = 1'b0; frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(model_out());
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit ks_r;
        reset = 1'b1; key_start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset(1'b0);
        chk("rst_state", game_state, 0);
        chk("rst_lives", lives, 0);
        chk("rst_rgb", rgb_sel, 0);

        // start a game
        cycle(1'b0, 1'b0, 1'b0);
        press();
        chk("start_state", game_state, 1);
        chk("start_objrst", object_reset, 1);
        chk("start_lives", lives, 3);
        chk("start_rgb", rgb_sel, 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("objrst_one_cycle", object_reset, 0);

        // first hit, collisions held through grace
        cycle(1'b0, 1'b1, 1'b0);
        chk("hit_state", game_state, 2);
        chk("hit_lives", lives, 2);
        chk("hit_vis0", obj_visible, 0);
        ticks(8, 1'b1);
        chk("hit_vis8", obj_visible, 1);
        ticks(51, 1'b1);
        chk("grace59_state", game_state, 2);
        chk("grace59_lives", lives, 2);
        cycle(1'b0, 1'b1, 1'b1);
        chk("grace60_state", game_state, 1);
        cycle(1'b0, 1'b0, 1'b0);

        // second and third hits
        cycle(1'b0, 1'b1, 1'b0);
        chk("hit2_lives", lives, 1);
        ticks(GRACE, 1'b0);
        chk("hit2_back", game_state, 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("over_state", game_state, 3);
        chk("over_lives", lives, 0);
        chk("over_goo", game_over_object, 1);
        chk("over_rgb", rgb_sel, 2);
        chk("over_en", game_en, 0);

        // over hold
        ticks(50, 1'b0);
        press();
        chk("over_early_start", game_state, 3);
        ticks(72, 1'b0);
        press();
        chk("restart_state", game_state, 1);
        chk("restart_lives", lives, 3);
        chk("restart_objrst", object_reset, 1);
`ifdef GAME_CTRL_SCORE_EN
        chk("score_new_game", score, 0);
        ticks(100, 1'b0);
        chk("score_100", score, 100);
`endif

        // key held through reset release, then coincident collision and tick
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("held_key_idle", game_state, 0);
        cycle(1'b0, 1'b0, 1'b0);
        press();
        chk("post_reset_start", game_state, 1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("coinc_state", game_state, 2);
        ticks(59, 1'b0);
        chk("coinc_grace59", game_state, 2);
        cycle(1'b0, 1'b0, 1'b1);
        chk("coinc_grace60", game_state, 1);

        // randomized phase
        ks_r = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 9) == 0) ks_r = ~ks_r;
            if ($urandom_range(0, 999) == 0) apply_reset(ks_r);
            else cycle(ks_r, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
